// File: rtl/ysyx_040750_rr_arbiter.sv
// Round-robin, transaction-locked arbiter producing a registered one-hot mux select.
// A grant is held until I_done; priority then rotates past the last winner.
module ysyx_040750_rr_arbiter #(
  parameter int M   = 4,
  parameter int IDW = $clog2(M)
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  input  logic [M-1:0]   I_req,
  input  logic           I_done,
  output logic [M-1:0]   O_grant,
  output logic [IDW-1:0] O_grant_id,
  output logic           O_valid
);

  // state  | meaning
  // S_IDLE | no grant outstanding, arbitrate from r_ptr on any request
  // S_BUSY | grant locked until I_done, then re-arbitrate from last winner + 1
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [M-1:0]   r_grant, w_grant_nxt;
  logic [IDW-1:0] r_grant_id, w_grant_id_nxt;
  logic           r_valid, w_valid_nxt;

  logic [IDW-1:0] w_ptr_inc;
  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_win;
  logic           w_found;
  logic [M-1:0]   w_win_onehot;

  assign w_ptr_inc    = (r_grant_id == IDW'(M-1)) ? '0 : r_grant_id + 1'b1;
  // On completion the search already starts from the rotated pointer
  assign w_base       = (r_state == S_BUSY) ? w_ptr_inc : r_ptr;
  assign w_win_onehot = {{(M-1){1'b0}}, 1'b1} << w_win;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < M; k++) begin
      w_idx = IDW'((int'(w_base) + k) % M);
      if (!w_found && I_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_valid_nxt    = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt    = w_win_onehot;
          w_grant_id_nxt = w_win;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (I_done) begin
          w_ptr_nxt = w_ptr_inc;
          if (w_found) begin
            w_grant_nxt    = w_win_onehot;
            w_grant_id_nxt = w_win;
          end else begin
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign O_grant    = r_grant;
  assign O_grant_id = r_grant_id;
  assign O_valid    = r_valid;

endmodule

// File: tb/tb_ysyx_040750_rr_arbiter.sv
// Directed + randomized bench for the round-robin arbiter against a transaction-level model.
module tb_ysyx_040750_rr_arbiter;

  localparam int M   = 4;
  localparam int IDW = $clog2(M);

  logic           I_clk;
  logic           I_rst_n;
  logic [M-1:0]   I_req;
  logic           I_done;
  logic [M-1:0]   O_grant;
  logic [IDW-1:0] O_grant_id;
  logic           O_valid;

  int checks;
  int failures;

  // Reference model: who owns the port, and who gets first look next time
  int       m_ptr;
  int       m_owner;
  bit       m_busy;

  ysyx_040750_rr_arbiter #(.M(M), .IDW(IDW)) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_req      (I_req),
    .I_done     (I_done),
    .O_grant    (O_grant),
    .O_grant_id (O_grant_id),
    .O_valid    (O_valid)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  function automatic int pick(input int start, input logic [M-1:0] req);
    for (int k = 0; k < M; k++) begin
      if (req[(start + k) % M]) return (start + k) % M;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = 0;
    m_busy  = 0;
  endtask

  task automatic model_step(input logic [M-1:0] req, input logic done);
    int w;
    if (!m_busy) begin
      w = pick(m_ptr, req);
      if (w >= 0) begin
        m_owner = w;
        m_busy  = 1;
      end
    end else if (done) begin
      m_ptr = (m_owner + 1) % M;
      w = pick(m_ptr, req);
      if (w >= 0) m_owner = w;
      else        m_busy  = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [M-1:0]   exp_grant;
    logic [IDW-1:0] exp_id;
    exp_grant = m_busy ? (M'(1) << m_owner) : '0;
    exp_id    = IDW'(m_owner);
    checks++;
    assert (O_grant === exp_grant)
      else begin failures++; $error("FAIL %s grant observed=%b expected=%b", tag, O_grant, exp_grant); end
    checks++;
    assert (O_grant_id === exp_id)
      else begin failures++; $error("FAIL %s grant_id observed=%0d expected=%0d", tag, O_grant_id, exp_id); end
    checks++;
    assert (O_valid === m_busy)
      else begin failures++; $error("FAIL %s valid observed=%b expected=%b", tag, O_valid, m_busy); end
    checks++;
    assert ($countones(O_grant) <= 1)
      else begin failures++; $error("FAIL %s onehot observed=%b expected=at-most-one-bit", tag, O_grant); end
  endtask

  // Drive inputs between edges, let one edge pass, then compare
  task automatic cycle(input logic [M-1:0] req, input logic done, input string tag);
    I_req  = req;
    I_done = done;
    @(posedge I_clk);
    model_step(req, done);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    I_rst_n  = 1'b0;
    I_req    = '0;
    I_done   = 1'b0;
    model_reset();

    repeat (3) @(posedge I_clk);
    #3;
    check_outputs("reset_held");
    I_rst_n = 1'b1;

    for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0, "idle");
    cycle(4'b0000, 1'b1, "idle_done_ignored");

    cycle(4'b0100, 1'b0, "single_grant");
    checks++;
    assert (O_grant === 4'b0100)
      else begin failures++; $error("FAIL single_const observed=%b expected=%b", O_grant, 4'b0100); end
    cycle(4'b0000, 1'b1, "single_release");

    cycle(4'b0101, 1'b0, "wrap_first");
    checks++;
    assert (O_grant === 4'b0001)
      else begin failures++; $error("FAIL wrap_const observed=%b expected=%b", O_grant, 4'b0001); end
    cycle(4'b0101, 1'b1, "wrap_second");
    checks++;
    assert (O_grant === 4'b0100)
      else begin failures++; $error("FAIL wrap2_const observed=%b expected=%b", O_grant, 4'b0100); end
    cycle(4'b0000, 1'b1, "wrap_release");

    for (int i = 0; i < 15; i++) cycle(4'b1111, (i % 3) == 2, "fairness");
    cycle(4'b0000, 1'b1, "fairness_release");

    cycle(4'b0010, 1'b0, "lock_grant");
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, "lock_hold");
    checks++;
    assert (O_grant === 4'b0010)
      else begin failures++; $error("FAIL lock_const observed=%b expected=%b", O_grant, 4'b0010); end
    cycle(4'b0001, 1'b1, "lock_switch");
    checks++;
    assert (O_grant === 4'b0001)
      else begin failures++; $error("FAIL lock_switch_const observed=%b expected=%b", O_grant, 4'b0001); end
    cycle(4'b0000, 1'b1, "lock_release");

    // Grant requester 3, then hit reset between edges
    cycle(4'b1000, 1'b0, "midrst_grant");
    cycle(4'b1000, 1'b0, "midrst_hold");
    #2;
    I_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst_async");
    @(negedge I_clk);
    I_rst_n = 1'b1;
    cycle(4'b1010, 1'b0, "after_reset");
    checks++;
    assert (O_grant === 4'b0010)
      else begin failures++; $error("FAIL after_reset_const observed=%b expected=%b", O_grant, 4'b0010); end

    for (int i = 0; i < 400; i++)
      cycle(M'($urandom_range(0, (1 << M) - 1)), $urandom_range(0, 2) == 0, "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
